// File: rtl/scalar_wb_stage_if.sv
// Bundles the writeback stage signals: ALU result handshake, load issue/return,
// register file write port and the decode-side forwarding/hazard port.
interface scalar_wb_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              alu_vld;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_rdy;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_issue_dst;
    logic              ld_vld;
    logic [ADDR_W-1:0] ld_dst;
    logic [DATA_W-1:0] ld_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rf_data_1;
    logic [DATA_W-1:0] rf_data_2;
    logic [DATA_W-1:0] fwd_data_1;
    logic [DATA_W-1:0] fwd_data_2;
    logic              hazard_1;
    logic              hazard_2;

    // Stage side.
    modport slave (
        input  alu_vld, alu_dst, alu_data, ld_issue, ld_issue_dst,
        input  ld_vld, ld_dst, ld_data, rd_addr_1, rd_addr_2, rf_data_1, rf_data_2,
        output alu_rdy, wr_en, wr_dst, wr_data, fwd_data_1, fwd_data_2, hazard_1, hazard_2
    );

    // Pipeline / environment side.
    modport master (
        output alu_vld, alu_dst, alu_data, ld_issue, ld_issue_dst,
        output ld_vld, ld_dst, ld_data, rd_addr_1, rd_addr_2, rf_data_1, rf_data_2,
        input  alu_rdy, wr_en, wr_dst, wr_data, fwd_data_1, fwd_data_2, hazard_1, hazard_2
    );
endinterface

// File: rtl/scalar_wb_stage.sv
// Writeback stage: merges load returns (highest priority, never stalled) with ALU
// results (valid/ready, skid FIFO), tracks pending loads per register, and
// forwards the registered write to the decode read ports.
module scalar_wb_stage #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    scalar_wb_stage_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned NReg = 2 ** ADDR_W;

    logic [ADDR_W-1:0] fifo_dst_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [NReg-1:0]   pend_q, pend_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dst_q, wr_dst_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic                  alu_rdy;
    logic                  alu_fire;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [FIFO_DEPTH-1:0] ent_vld;
    logic                  fifo_hit_1;
    logic                  fifo_hit_2;

    // Ready is held low through reset so nothing is accepted into a FIFO being cleared.
    assign alu_rdy    = !rst && (count_q < CntW'(FIFO_DEPTH));
    assign alu_fire   = bus.alu_vld && alu_rdy;
    assign fifo_empty = (count_q == '0);

    // Write-source selection: load, then FIFO head, then direct ALU bypass.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_dst_d  = wr_dst_q;
        wr_data_d = wr_data_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (bus.ld_vld) begin
            wr_en_d   = 1'b1;
            wr_dst_d  = bus.ld_dst;
            wr_data_d = bus.ld_data;
            push      = alu_fire;
        end else if (!fifo_empty) begin
            wr_en_d   = 1'b1;
            wr_dst_d  = fifo_dst_q[rd_ptr_q];
            wr_data_d = fifo_data_q[rd_ptr_q];
            pop       = 1'b1;
            push      = alu_fire;
        end else if (alu_fire) begin
            wr_en_d   = 1'b1;
            wr_dst_d  = bus.alu_dst;
            wr_data_d = bus.alu_data;
        end
    end

    // FIFO pointer/count next state; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // Scoreboard next state; a set applied after the clear wins on the same register.
    always_comb begin
        pend_d = pend_q;
        if (bus.ld_vld) begin
            pend_d[bus.ld_dst] = 1'b0;
        end
        if (bus.ld_issue) begin
            pend_d[bus.ld_issue_dst] = 1'b1;
        end
    end

    // Control state and write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_dst_q  <= wr_dst_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage; contents are don't-care outside the valid window so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dst_q[wr_ptr_q]  <= bus.alu_dst;
            fifo_data_q[wr_ptr_q] <= bus.alu_data;
        end
    end

    // An entry is valid when its distance from the head is below the occupancy.
    always_comb begin
        ent_vld = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PtrW'(i) - rd_ptr_q} < count_q);
        end
    end

    // Match decode read addresses against queued ALU destinations.
    always_comb begin
        fifo_hit_1 = 1'b0;
        fifo_hit_2 = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_vld[i] && (fifo_dst_q[i] == bus.rd_addr_1)) begin
                fifo_hit_1 = 1'b1;
            end
            if (ent_vld[i] && (fifo_dst_q[i] == bus.rd_addr_2)) begin
                fifo_hit_2 = 1'b1;
            end
        end
    end

    assign bus.alu_rdy    = alu_rdy;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_dst     = wr_dst_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.hazard_1   = pend_q[bus.rd_addr_1] | fifo_hit_1;
    assign bus.hazard_2   = pend_q[bus.rd_addr_2] | fifo_hit_2;
    assign bus.fwd_data_1 = (wr_en_q && (wr_dst_q == bus.rd_addr_1)) ? wr_data_q : bus.rf_data_1;
    assign bus.fwd_data_2 = (wr_en_q && (wr_dst_q == bus.rd_addr_2)) ? wr_data_q : bus.rf_data_2;
endmodule

// File: tb/tb_scalar_wb_stage.sv
// Directed bench for scalar_wb_stage: vector table plus backpressure and reset sequences.
module tb_scalar_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam logic [15:0] RF1 = 16'hF001;
    localparam logic [15:0] RF2 = 16'hF002;

    always #5 clk = ~clk;

    scalar_wb_stage_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    scalar_wb_stage #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        av;  logic [2:0] ad;  logic [15:0] adata;
        logic        li;  logic [2:0] lid;
        logic        lv;  logic [2:0] ld;  logic [15:0] ldata;
        logic [2:0]  r1;  logic [2:0] r2;
        logic        rdy; logic h1; logic h2; logic [15:0] f1; logic [15:0] f2;
        logic        we;  logic [2:0] wd;  logic [15:0] wdata;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.alu_vld = 0; bus.alu_dst = 0; bus.alu_data = 0;
        bus.ld_issue = 0; bus.ld_issue_dst = 0;
        bus.ld_vld = 0; bus.ld_dst = 0; bus.ld_data = 0;
        bus.rd_addr_1 = 0; bus.rd_addr_2 = 0;
        bus.rf_data_1 = RF1; bus.rf_data_2 = RF2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor with its own pending-register model.
    logic [7:0] tb_pend = '0;
    always @(posedge clk) begin
        if (rst) begin
            tb_pend <= '0;
        end else begin
            if (bus.ld_vld && !tb_pend[bus.ld_dst]) begin
                $display("FAIL proto_ld_vld: load return to non-pending r%0d", bus.ld_dst);
                bad++;
            end
            if (bus.ld_issue && tb_pend[bus.ld_issue_dst] &&
                !(bus.ld_vld && bus.ld_dst == bus.ld_issue_dst)) begin
                $display("FAIL proto_ld_issue: issue to pending r%0d", bus.ld_issue_dst);
                bad++;
            end
            if (bus.alu_vld && bus.alu_rdy && tb_pend[bus.alu_dst]) begin
                $display("FAIL proto_alu: ALU write to pending r%0d", bus.alu_dst);
                bad++;
            end
            tb_pend <= (tb_pend & ~(bus.ld_vld ? (8'b1 << bus.ld_dst) : 8'b0))
                     | (bus.ld_issue ? (8'b1 << bus.ld_issue_dst) : 8'b0);
        end
    end

    function automatic vec_t mk(
        logic av, logic [2:0] ad, logic [15:0] adata, logic li, logic [2:0] lid,
        logic lv, logic [2:0] ld, logic [15:0] ldata, logic [2:0] r1, logic [2:0] r2,
        logic rdy, logic h1, logic h2, logic [15:0] f1, logic [15:0] f2,
        logic we, logic [2:0] wd, logic [15:0] wdata);
        vec_t v;
        v.av = av; v.ad = ad; v.adata = adata; v.li = li; v.lid = lid;
        v.lv = lv; v.ld = ld; v.ldata = ldata; v.r1 = r1; v.r2 = r2;
        v.rdy = rdy; v.h1 = h1; v.h2 = h2; v.f1 = f1; v.f2 = f2;
        v.we = we; v.wd = wd; v.wdata = wdata;
        return v;
    endfunction

    logic [2:0]  exp_dst  [10];
    logic [15:0] exp_data [10];
    logic [2:0]  got_dst  [16];
    logic [15:0] got_data [16];
    logic [2:0]  alu_dsts [6];

    initial begin
        int n_got;
        int idx;
        //          ALU             issue  load              rd    comb                        reg
        vecs[0]  = mk(1,3,16'h1234, 0,0, 0,0,16'h0000, 3,0, 1,0,0,RF1,RF2,         1,3,16'h1234);
        vecs[1]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 3,3, 1,0,0,16'h1234,16'h1234, 0,3,16'h1234);
        vecs[2]  = mk(0,0,16'h0000, 1,1, 0,0,16'h0000, 1,0, 1,0,0,RF1,RF2,         0,3,16'h1234);
        vecs[3]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 1,0, 1,1,0,RF1,RF2,         0,3,16'h1234);
        vecs[4]  = mk(1,2,16'h5555, 0,0, 1,1,16'hAAAA, 1,2, 1,1,0,RF1,RF2,         1,1,16'hAAAA);
        vecs[5]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 2,1, 1,1,0,RF1,16'hAAAA,    1,2,16'h5555);
        vecs[6]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 2,0, 1,0,0,16'h5555,RF2,    0,2,16'h5555);
        vecs[7]  = mk(0,0,16'h0000, 1,5, 0,0,16'h0000, 0,5, 1,0,0,RF1,RF2,         0,2,16'h5555);
        vecs[8]  = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 0,5, 1,0,1,RF1,RF2,         0,2,16'h5555);
        vecs[9]  = mk(0,0,16'h0000, 0,0, 1,5,16'hBEEF, 0,5, 1,0,1,RF1,RF2,         1,5,16'hBEEF);
        vecs[10] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 0,5, 1,0,0,RF1,16'hBEEF,    0,5,16'hBEEF);
        vecs[11] = mk(0,0,16'h0000, 1,6, 0,0,16'h0000, 6,0, 1,0,0,RF1,RF2,         0,5,16'hBEEF);
        vecs[12] = mk(0,0,16'h0000, 1,6, 1,6,16'h0606, 6,0, 1,1,0,RF1,RF2,         1,6,16'h0606);
        vecs[13] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 6,0, 1,1,0,16'h0606,RF2,    0,6,16'h0606);
        vecs[14] = mk(0,0,16'h0000, 0,0, 1,6,16'h0660, 6,0, 1,1,0,RF1,RF2,         1,6,16'h0660);
        vecs[15] = mk(0,0,16'h0000, 0,0, 0,0,16'h0000, 6,0, 1,0,0,16'h0660,RF2,    0,6,16'h0660);
        vecs[16] = mk(1,0,16'h00A0, 0,0, 0,0,16'h0000, 0,0, 1,0,0,RF1,RF2,         1,0,16'h00A0);

        // Reset behaviour.
        idle();
        @(negedge clk);
        chk("rst_alu_rdy", 32'(bus.alu_rdy), 0);
        tick();
        tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_dst", 32'(bus.wr_dst), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_alu_rdy", 32'(bus.alu_rdy), 1);
        chk("post_rst_hazard_1", 32'(bus.hazard_1), 0);
        chk("post_rst_hazard_2", 32'(bus.hazard_2), 0);
        tick();

        // Vector table: combinational checks mid-cycle, registered checks after the edge.
        for (int i = 0; i < 17; i++) begin
            idle();
            bus.alu_vld = vecs[i].av; bus.alu_dst = vecs[i].ad; bus.alu_data = vecs[i].adata;
            bus.ld_issue = vecs[i].li; bus.ld_issue_dst = vecs[i].lid;
            bus.ld_vld = vecs[i].lv; bus.ld_dst = vecs[i].ld; bus.ld_data = vecs[i].ldata;
            bus.rd_addr_1 = vecs[i].r1; bus.rd_addr_2 = vecs[i].r2;
            @(negedge clk);
            chk($sformatf("v%0d_alu_rdy", i), 32'(bus.alu_rdy), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_hazard_1", i), 32'(bus.hazard_1), 32'(vecs[i].h1));
            chk($sformatf("v%0d_hazard_2", i), 32'(bus.hazard_2), 32'(vecs[i].h2));
            chk($sformatf("v%0d_fwd_1", i), 32'(bus.fwd_data_1), 32'(vecs[i].f1));
            chk($sformatf("v%0d_fwd_2", i), 32'(bus.fwd_data_2), 32'(vecs[i].f2));
            tick();
            chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].we));
            chk($sformatf("v%0d_wr_dst", i), 32'(bus.wr_dst), 32'(vecs[i].wd));
            chk($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].wdata));
        end
        idle();
        @(negedge clk);
        chk("reg0_fwd_1", 32'(bus.fwd_data_1), 32'h00A0);
        tick();

        // Backpressure: four back-to-back load returns with a continuous ALU stream.
        alu_dsts[0] = 5; alu_dsts[1] = 6; alu_dsts[2] = 7;
        alu_dsts[3] = 0; alu_dsts[4] = 5; alu_dsts[5] = 6;
        for (int k = 0; k < 4; k++) begin
            exp_dst[k] = 3'(k + 1);
            exp_data[k] = 16'h1001 + 16'(k);
        end
        for (int k = 0; k < 6; k++) begin
            exp_dst[k + 4] = alu_dsts[k];
            exp_data[k + 4] = 16'hC000 + 16'(k);
        end
        for (int k = 1; k <= 4; k++) begin
            bus.ld_issue = 1; bus.ld_issue_dst = 3'(k);
            tick();
        end
        idle();
        n_got = 0;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.wr_en && n_got < 16) begin
                got_dst[n_got] = bus.wr_dst;
                got_data[n_got] = bus.wr_data;
                n_got++;
            end
            bus.ld_vld = (c < 4);
            bus.ld_dst = (c < 4) ? 3'(c + 1) : 3'd0;
            bus.ld_data = (c < 4) ? 16'h1001 + 16'(c) : 16'h0000;
            bus.alu_vld = (idx < 6);
            bus.alu_dst = (idx < 6) ? alu_dsts[idx] : 3'd0;
            bus.alu_data = (idx < 6) ? 16'hC000 + 16'(idx) : 16'h0000;
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("bp_alu_rdy_c%0d", c), 32'(bus.alu_rdy), (c < 2) ? 1 : 0);
            end
            if (bus.alu_vld && bus.alu_rdy) idx++;
            tick();
        end
        idle();
        chk("bp_alu_sent", 32'(idx), 6);
        chk("bp_write_count", 32'(n_got), 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_wr%0d_dst", k), 32'(got_dst[k]), 32'(exp_dst[k]));
            chk($sformatf("bp_wr%0d_data", k), 32'(got_data[k]), 32'(exp_data[k]));
        end

        // Reset mid-run with a full FIFO and a pending load.
        bus.ld_issue = 1; bus.ld_issue_dst = 4; tick();
        bus.ld_issue_dst = 1; tick();
        bus.ld_issue_dst = 2; tick();
        bus.ld_issue = 0;
        bus.ld_vld = 1; bus.ld_dst = 1; bus.ld_data = 16'h2001;
        bus.alu_vld = 1; bus.alu_dst = 3; bus.alu_data = 16'hD003;
        tick();
        bus.ld_dst = 2; bus.ld_data = 16'h2002;
        bus.alu_dst = 5; bus.alu_data = 16'hD005;
        tick();
        idle();
        bus.rd_addr_1 = 3; bus.rd_addr_2 = 4;
        @(negedge clk);
        chk("full_alu_rdy", 32'(bus.alu_rdy), 0);
        chk("full_hazard_1", 32'(bus.hazard_1), 1);
        chk("full_hazard_2", 32'(bus.hazard_2), 1);
        rst = 1;
        tick();
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        @(negedge clk);
        chk("midrst_alu_rdy", 32'(bus.alu_rdy), 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("after_rst_alu_rdy", 32'(bus.alu_rdy), 1);
        chk("after_rst_hazard_1", 32'(bus.hazard_1), 0);
        chk("after_rst_hazard_2", 32'(bus.hazard_2), 0);
        chk("after_rst_wr_en", 32'(bus.wr_en), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("no_stale_wr_%0d", k), 32'(bus.wr_en), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
